mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- MEM pipeline stage of the MIPS core, directly upstream of the word-organised data memory.
- Converts EX/MEM load/store requests (byte address, size, signedness) into word address, byte-lane mask and lane-replicated store data for the memory.
- Extracts and extends the load word the memory returns.
- Registers the writeback result into the MEM/WB pipeline register, with stall, flush and misalignment detection.

Parameters:
- DWIDTH, 32, data width; fixed at 32 (four byte lanes).
- WORD_AW, 5, width of the word address driven to memory.

Ports:
- m_clk  in  1  clock; MEM/WB register updates on posedge.
- m_rst  in  1  reset, asynchronous, active-low.
- i_valid  in  1  EX/MEM holds a live instruction.
- i_load  in  1  instruction is a load.
- i_store  in  1  instruction is a store. i_load and i_store are never both 1.
- i_size  in  2  access size: 00 byte, 01 half, 10 word, 11 treated as word.
- i_unsigned  in  1  zero-extend loads (LBU/LHU).
- i_addr  in  32  byte address from the ALU.
- i_store_data  in  DWIDTH  rt value for stores.
- i_alu_result  in  DWIDTH  non-load writeback value.
- i_rd  in  5  destination register.
- i_reg_wr  in  1  instruction writes a register.
- i_stall  in  1  hold MEM/WB; suppress memory write.
- i_flush  in  1  kill the current instruction; priority over i_stall.
- o_mem_ce  out  1  memory chip enable.
- o_mem_wr_en  out  1  memory write enable.
- o_mem_addr  out  WORD_AW  word address = i_addr[WORD_AW+1:2].
- o_mem_mask  out  4  byte-lane write mask.
- o_mem_store_data  out  DWIDTH  lane-replicated store data.
- i_mem_load_data  in  DWIDTH  combinational read data from memory.
- o_wb_valid  out  1  MEM/WB holds a live instruction.
- o_wb_reg_wr  out  1  register write enable to WB.
- o_wb_rd  out  5  destination register.
- o_wb_data  out  DWIDTH  writeback value.
- o_misalign  out  1  one-cycle pulse: a misaligned access retired.
- o_misalign_addr  out  32  byte address of the last misaligned access.

Behaviour:
- Lanes are little-endian: lane k = bits [8k+7:8k], selected by i_addr[1:0]=k.
- Misaligned access: half with i_addr[0]=1, or word with i_addr[1:0]≠00.
- Memory-side outputs are combinational from current inputs.
  - live = i_valid & ~i_flush & ~misaligned.
  - o_mem_ce = live & (i_load | i_store).
  - o_mem_wr_en = live & i_store & ~i_stall.
  - Memory writes on the following negedge, so a store completes within its MEM cycle.
- Store encoding:
  - byte: mask = 1<<i_addr[1:0], data = {4{sd[7:0]}}.
  - half: mask = 0011 (addr[1]=0) or 1100 (addr[1]=1), data = {2{sd[15:0]}}.
  - word: mask = 1111, data = sd.
  - Non-store: mask 0000, data = sd.
- Load extraction: select byte or half by i_addr; sign-extend unless i_unsigned; word passes through. wb value = i_load ? extracted : i_alu_result.
- MEM/WB register, evaluated in priority order (first match wins):
  - m_rst=0: o_wb_valid, o_wb_reg_wr, o_wb_rd, o_wb_data, o_misalign, o_misalign_addr all 0, immediately and asynchronously.
  - i_flush=1: o_wb_valid=0, o_wb_reg_wr=0, o_misalign=0; rd/data don't-care (clear to 0).
  - i_stall=1: all MEM/WB fields hold; o_misalign=0; no memory write.
  - Otherwise: o_wb_valid=i_valid; o_wb_rd=i_rd; o_wb_data=wb value.
    - o_wb_reg_wr = i_valid & i_reg_wr & ~misaligned.
    - o_misalign = i_valid & (i_load|i_store) & misaligned.
    - On a misaligned access, o_misalign_addr <= i_addr; it holds until the next misaligned access or reset.
- Latency: load data appears in o_wb_data one posedge after the request; store has no WB effect unless i_reg_wr is set.
- Reset mid-store: memory signals gate off via i_valid from the upstream reset; no partial-lane guarantee beyond the memory's own reset.

Test Plan:
- Reset, then LW addr 0x0000000C (memory word 3 = 0x00000003) → o_mem_addr=3, ce=1, wr_en=0; next cycle o_wb_data=0x00000003, o_wb_reg_wr=1.
- SB sd=0x000000A5 to addr 0x0000000E → mask=0100, store_data=0xA5A5A5A5, wr_en=1. Then LB addr 0x0E → o_wb_data=0xFFFFFFA5; LBU → 0x000000A5.
- SH sd=0x00008001 to addr 0x12 → mask=1100, data=0x80018001. Then LH addr 0x12 → 0xFFFF8001; LW addr 0x10 → 0x80010004.
- LW addr 0x00000005 (misaligned) → ce=0, wr_en=0; next cycle o_misalign=1 for exactly one cycle, o_wb_reg_wr=0, o_misalign_addr=0x00000005.
- SW with i_stall=1 for 2 cycles, then 0 → wr_en=0 during stall, MEM/WB outputs frozen; write occurs only in the unstalled cycle.
- SW with i_flush=1 and i_stall=1 together → no write, next cycle o_wb_valid=0. Assert m_rst=0 mid-cycle → all WB outputs 0 before the next edge.

Source files
------------

// File: rtl/mem_access_stage_if.sv
// Memory-side bus between the MEM stage and the word-organised data memory.
// Latency: none; purely a bundle of wires.
// Backpressure: none; the memory accepts a request every cycle.
interface mem_access_stage_if #(
  parameter int DWIDTH  = 32,
  parameter int WORD_AW = 5
);
  logic               o_mem_ce;
  logic               o_mem_wr_en;
  logic [WORD_AW-1:0] o_mem_addr;
  logic [3:0]         o_mem_mask;
  logic [DWIDTH-1:0]  o_mem_store_data;
  logic [DWIDTH-1:0]  i_mem_load_data;

  // The pipeline stage drives requests and consumes read data
  modport master (
    output o_mem_ce, o_mem_wr_en, o_mem_addr, o_mem_mask, o_mem_store_data,
    input  i_mem_load_data
  );

  // The memory consumes requests and drives read data
  modport slave (
    input  o_mem_ce, o_mem_wr_en, o_mem_addr, o_mem_mask, o_mem_store_data,
    output i_mem_load_data
  );
endinterface

// File: rtl/mem_access_stage.sv
// MEM stage: byte-address to word/lane request, load extract/extend, MEM/WB register.
// Latency: memory request combinational; writeback result one m_clk posedge later.
// Backpressure: i_stall holds MEM/WB and blocks memory writes; i_flush overrides i_stall.
module mem_access_stage #(
  parameter int DWIDTH  = 32,
  parameter int WORD_AW = 5
) (
  input  logic              m_clk,
  input  logic              m_rst,
  input  logic              i_valid,
  input  logic              i_load,
  input  logic              i_store,
  input  logic [1:0]        i_size,
  input  logic              i_unsigned,
  input  logic [31:0]       i_addr,
  input  logic [DWIDTH-1:0] i_store_data,
  input  logic [DWIDTH-1:0] i_alu_result,
  input  logic [4:0]        i_rd,
  input  logic              i_reg_wr,
  input  logic              i_stall,
  input  logic              i_flush,
  mem_access_stage_if.master mem_bus,
  output logic              o_wb_valid,
  output logic              o_wb_reg_wr,
  output logic [4:0]        o_wb_rd,
  output logic [DWIDTH-1:0] o_wb_data,
  output logic              o_misalign,
  output logic [31:0]       o_misalign_addr
);

  logic              w_misaligned;
  logic              w_live;
  logic [3:0]        w_mask;
  logic [DWIDTH-1:0] w_store_data;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [DWIDTH-1:0] w_load_ext;
  logic [DWIDTH-1:0] w_wb_value;

  // Size 11 behaves as a word, so any size with bit 1 set needs word alignment
  assign w_misaligned = ((i_size == 2'b01) & i_addr[0]) |
                        (i_size[1] & (i_addr[1:0] != 2'b00));
  assign w_live       = i_valid & ~i_flush & ~w_misaligned;

  assign mem_bus.o_mem_ce         = w_live & (i_load | i_store);
  assign mem_bus.o_mem_wr_en      = w_live & i_store & ~i_stall;
  assign mem_bus.o_mem_addr       = i_addr[WORD_AW+1:2];
  assign mem_bus.o_mem_mask       = w_mask;
  assign mem_bus.o_mem_store_data = w_store_data;

  // Store lane mask and lane-replicated data; the mask alone picks the written lanes
  always_comb begin
    w_mask       = 4'b0000;
    w_store_data = i_store_data;
    if (i_store) begin
      case (i_size)
        2'b00: begin
          w_mask       = 4'b0001 << i_addr[1:0];
          w_store_data = {4{i_store_data[7:0]}};
        end
        2'b01: begin
          w_mask       = i_addr[1] ? 4'b1100 : 4'b0011;
          w_store_data = {2{i_store_data[15:0]}};
        end
        default: begin
          w_mask       = 4'b1111;
          w_store_data = i_store_data;
        end
      endcase
    end
  end

  // Pick the addressed byte/half of the returned word (little-endian lanes)
  always_comb begin
    w_byte = mem_bus.i_mem_load_data[7:0];
    case (i_addr[1:0])
      2'b00:   w_byte = mem_bus.i_mem_load_data[7:0];
      2'b01:   w_byte = mem_bus.i_mem_load_data[15:8];
      2'b10:   w_byte = mem_bus.i_mem_load_data[23:16];
      default: w_byte = mem_bus.i_mem_load_data[31:24];
    endcase
    w_half = i_addr[1] ? mem_bus.i_mem_load_data[31:16] : mem_bus.i_mem_load_data[15:0];
  end

  // Sign- or zero-extend the selected lanes; words pass straight through
  always_comb begin
    w_load_ext = mem_bus.i_mem_load_data;
    case (i_size)
      2'b00:   w_load_ext = i_unsigned ? {{(DWIDTH-8){1'b0}}, w_byte}
                                       : {{(DWIDTH-8){w_byte[7]}}, w_byte};
      2'b01:   w_load_ext = i_unsigned ? {{(DWIDTH-16){1'b0}}, w_half}
                                       : {{(DWIDTH-16){w_half[15]}}, w_half};
      default: w_load_ext = mem_bus.i_mem_load_data;
    endcase
  end

  assign w_wb_value = i_load ? w_load_ext : i_alu_result;

  // MEM/WB register: flush kills, stall freezes, otherwise capture the retiring instruction
  always_ff @(posedge m_clk or negedge m_rst) begin
    if (!m_rst) begin
      o_wb_valid      <= 1'b0;
      o_wb_reg_wr     <= 1'b0;
      o_wb_rd         <= 5'd0;
      o_wb_data       <= '0;
      o_misalign      <= 1'b0;
      o_misalign_addr <= 32'd0;
    end else if (i_flush) begin
      o_wb_valid  <= 1'b0;
      o_wb_reg_wr <= 1'b0;
      o_wb_rd     <= 5'd0;
      o_wb_data   <= '0;
      o_misalign  <= 1'b0;
    end else if (i_stall) begin
      o_misalign <= 1'b0;
    end else begin
      o_wb_valid  <= i_valid;
      o_wb_reg_wr <= i_valid & i_reg_wr & ~w_misaligned;
      o_wb_rd     <= i_rd;
      o_wb_data   <= w_wb_value;
      o_misalign  <= i_valid & (i_load | i_store) & w_misaligned;
      if (i_valid & (i_load | i_store) & w_misaligned)
        o_misalign_addr <= i_addr;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

  logic        m_clk = 1'b0;
  logic        m_rst = 1'b0;
  logic        i_valid = 1'b0, i_load = 1'b0, i_store = 1'b0, i_unsigned = 1'b0;
  logic [1:0]  i_size = 2'b00;
  logic [31:0] i_addr = 32'd0, i_store_data = 32'd0, i_alu_result = 32'd0;
  logic [4:0]  i_rd = 5'd0;
  logic        i_reg_wr = 1'b0, i_stall = 1'b0, i_flush = 1'b0;
  logic        o_wb_valid, o_wb_reg_wr, o_misalign;
  logic [4:0]  o_wb_rd;
  logic [31:0] o_wb_data, o_misalign_addr;

  mem_access_stage_if #(.DWIDTH(32), .WORD_AW(5)) bus ();

  mem_access_stage #(.DWIDTH(32), .WORD_AW(5)) dut (
    .m_clk(m_clk), .m_rst(m_rst), .i_valid(i_valid), .i_load(i_load), .i_store(i_store),
    .i_size(i_size), .i_unsigned(i_unsigned), .i_addr(i_addr), .i_store_data(i_store_data),
    .i_alu_result(i_alu_result), .i_rd(i_rd), .i_reg_wr(i_reg_wr), .i_stall(i_stall),
    .i_flush(i_flush), .mem_bus(bus.master), .o_wb_valid(o_wb_valid),
    .o_wb_reg_wr(o_wb_reg_wr), .o_wb_rd(o_wb_rd), .o_wb_data(o_wb_data),
    .o_misalign(o_misalign), .o_misalign_addr(o_misalign_addr)
  );

  always #5 m_clk = ~m_clk;

  // Word-organised data memory: word k starts as k, writes land on negedge
  logic [31:0] mem [0:31];
  initial for (int k = 0; k < 32; k++) mem[k] = k;
  assign bus.i_mem_load_data = mem[bus.o_mem_addr];
  always @(negedge m_clk) begin
    if (bus.o_mem_wr_en)
      for (int k = 0; k < 4; k++)
        if (bus.o_mem_mask[k]) mem[bus.o_mem_addr][8*k +: 8] <= bus.o_mem_store_data[8*k +: 8];
  end

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        reg_wr;
    logic        mis;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every posedge that retires an instruction pops and compares one expectation
  logic mon_acc, mon_idle, mon_stall;
  exp_t mon_e;
  always begin
    @(posedge m_clk);
    mon_acc   = m_rst && i_valid && !i_stall && !i_flush;
    mon_idle  = m_rst && !mon_acc && (i_flush || !i_stall);
    mon_stall = m_rst && i_stall && !i_flush;
    #3;
    if (mon_acc) begin
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL wb_unexpected actual=retire required=none");
      end else begin
        mon_e = sb.pop_front();
        chk("wb_valid",    {31'd0, o_wb_valid},  32'd1);
        chk("wb_reg_wr",   {31'd0, o_wb_reg_wr}, {31'd0, mon_e.reg_wr});
        chk("wb_rd",       {27'd0, o_wb_rd},     {27'd0, mon_e.rd});
        chk("wb_data",     o_wb_data,            mon_e.data);
        chk("wb_misalign", {31'd0, o_misalign},  {31'd0, mon_e.mis});
      end
    end else if (mon_idle) begin
      chk("idle_valid",    {31'd0, o_wb_valid},  32'd0);
      chk("idle_reg_wr",   {31'd0, o_wb_reg_wr}, 32'd0);
      chk("idle_misalign", {31'd0, o_misalign},  32'd0);
    end else if (mon_stall) begin
      chk("stall_misalign", {31'd0, o_misalign}, 32'd0);
    end
  end

  // Drive one EX/MEM cycle, check memory-side outputs, queue the expected writeback
  task automatic issue(input logic v, input logic ld, input logic st, input logic [1:0] sz,
                       input logic uns, input logic [31:0] addr, input logic [31:0] sd,
                       input logic [4:0] rd, input logic rw, input logic stl, input logic fl,
                       input logic exp_ce, input logic exp_we, input logic [3:0] exp_mask,
                       input logic [31:0] exp_sdata, input logic [31:0] exp_wb,
                       input logic exp_mis);
    exp_t e;
    @(posedge m_clk);
    #1;
    i_valid = v; i_load = ld; i_store = st; i_size = sz; i_unsigned = uns;
    i_addr = addr; i_store_data = sd; i_alu_result = addr; i_rd = rd; i_reg_wr = rw;
    i_stall = stl; i_flush = fl;
    #1;
    chk("mem_ce",    {31'd0, bus.o_mem_ce},    {31'd0, exp_ce});
    chk("mem_wr_en", {31'd0, bus.o_mem_wr_en}, {31'd0, exp_we});
    chk("mem_addr",  {27'd0, bus.o_mem_addr},  {27'd0, addr[6:2]});
    if (exp_ce || !st) begin
      chk("mem_mask",  {28'd0, bus.o_mem_mask}, {28'd0, exp_mask});
      chk("mem_sdata", bus.o_mem_store_data,    exp_sdata);
    end
    if (v && !stl && !fl) begin
      e.rd = rd; e.data = exp_wb; e.reg_wr = rw & ~exp_mis; e.mis = (ld | st) & exp_mis;
      sb.push_back(e);
    end
  endtask

  task automatic idle();
    issue(0,0,0,2'b00,0,32'd0,32'd0,5'd0,0,0,0, 0,0,4'b0000,32'd0,32'd0,0);
  endtask

  initial begin
    #2;
    chk("rst_wb_valid", {31'd0, o_wb_valid},  32'd0);
    chk("rst_wb_data",  o_wb_data,            32'd0);
    chk("rst_mis_addr", o_misalign_addr,      32'd0);
    #10 m_rst = 1'b1;
    idle();
    //     v ld st sz    u addr          sd            rd  rw st fl ce we mask     sdata         wb            mis
    issue(1,1,0,2'b10,0,32'h0000000C,32'h0,       5'd1,1,0,0, 1,0,4'b0000,32'h0,        32'h00000003,0);
    issue(1,0,1,2'b00,0,32'h0000000E,32'h000000A5,5'd0,0,0,0, 1,1,4'b0100,32'hA5A5A5A5, 32'h0000000E,0);
    issue(1,1,0,2'b00,0,32'h0000000E,32'h0,       5'd2,1,0,0, 1,0,4'b0000,32'h0,        32'hFFFFFFA5,0);
    issue(1,1,0,2'b00,1,32'h0000000E,32'h0,       5'd3,1,0,0, 1,0,4'b0000,32'h0,        32'h000000A5,0);
    issue(1,0,1,2'b01,0,32'h00000012,32'h00008001,5'd0,0,0,0, 1,1,4'b1100,32'h80018001, 32'h00000012,0);
    issue(1,1,0,2'b01,0,32'h00000012,32'h0,       5'd4,1,0,0, 1,0,4'b0000,32'h0,        32'hFFFF8001,0);
    issue(1,1,0,2'b10,0,32'h00000010,32'h0,       5'd5,1,0,0, 1,0,4'b0000,32'h0,        32'h80010004,0);
    issue(1,1,0,2'b01,1,32'h00000012,32'h0,       5'd6,1,0,0, 1,0,4'b0000,32'h0,        32'h00008001,0);
    // Misaligned word load: no memory access, one-cycle misalign pulse, no register write
    issue(1,1,0,2'b10,0,32'h00000005,32'h0,       5'd7,1,0,0, 0,0,4'b0000,32'h0,        32'h00000001,1);
    idle();
    chk("mis_addr_5", o_misalign_addr, 32'h00000005);
    // Stall: SW held two cycles, MEM/WB frozen on the preceding load
    issue(1,1,0,2'b10,0,32'h0000000C,32'h0,       5'd8,1,0,0, 1,0,4'b0000,32'h0,        32'h00A50003,0);
    for (int s = 0; s < 2; s++) begin
      issue(1,0,1,2'b10,0,32'h00000018,32'h11223344,5'd0,0,1,0, 1,0,4'b1111,32'h11223344, 32'h0,0);
      chk("stall_rd",   {27'd0, o_wb_rd}, 32'd8);
      chk("stall_data", o_wb_data,        32'h00A50003);
      #4;
      chk("stall_nowrite", mem[6], 32'd6);
    end
    issue(1,0,1,2'b10,0,32'h00000018,32'h11223344,5'd0,0,0,0, 1,1,4'b1111,32'h11223344, 32'h00000018,0);
    issue(1,1,0,2'b10,0,32'h00000018,32'h0,       5'd9,1,0,0, 1,0,4'b0000,32'h0,        32'h11223344,0);
    // Flush beats stall: nothing written, next cycle not valid
    issue(1,0,1,2'b10,0,32'h0000001C,32'hFFFFFFFF,5'd0,0,1,1, 0,0,4'b0000,32'h0,        32'h0,0);
    issue(1,1,0,2'b10,0,32'h0000001C,32'h0,       5'd10,1,0,0,1,0,4'b0000,32'h0,        32'h00000007,0);
    idle();
    // Asynchronous reset mid-cycle clears MEM/WB before the next edge
    #3 m_rst = 1'b0;
    #1;
    chk("arst_wb_valid",  {31'd0, o_wb_valid},  32'd0);
    chk("arst_wb_reg_wr", {31'd0, o_wb_reg_wr}, 32'd0);
    chk("arst_wb_rd",     {27'd0, o_wb_rd},     32'd0);
    chk("arst_wb_data",   o_wb_data,            32'd0);
    chk("arst_mis_addr",  o_misalign_addr,      32'd0);
    #8 m_rst = 1'b1;
    idle();
    idle();
    chk("sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
